// File: rtl/uart_pkg.sv
// Shared types, baud table and helpers for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      FRAME_5 = 2'b00,
      FRAME_6 = 2'b01,
      FRAME_7 = 2'b10,
      FRAME_8 = 2'b11
   } frame_t;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10,
      PAR_RSVD = 2'b11
   } parity_t;

   typedef enum logic {
      STOP_1 = 1'b0,
      STOP_2 = 1'b1
   } stop_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int unsigned BAUD_TABLE [16] = '{
      300, 600, 1200, 1800, 2400, 4800, 7200, 9600,
      14400, 19200, 38400, 57600, 115200, 230400, 460800, 921600
   };

   // Bit period minus one, rounded to the nearest clock.
   function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [3:0] idx);
      int unsigned baud;
      baud = BAUD_TABLE[idx];
      return ((clk_hz + (baud / 2)) / baud) - 1;
   endfunction

   // Keeps only the data bits that belong to the frame.
   function automatic logic [7:0] data_mask(input frame_t f);
      return 8'hFF >> (2'd3 - f);
   endfunction

   // Index of the final data bit (N-1).
   function automatic logic [2:0] last_bit_idx(input frame_t f);
      return {1'b0, f} + 3'd4;
   endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Control-register side of the transmit engine: config fields and the tnsm request/retire pair.
interface uart_tx_engine_if;
   import uart_pkg::*;

   logic        active;
   frame_t      frame_type;
   parity_t     parity_type;
   stop_t       stop_type;
   logic [3:0]  baud_rate;
   logic        tnsm;
   logic [7:0]  tnsm_data;
   logic        tnsm_clr;

   modport master (
      output active, frame_type, parity_type, stop_type, baud_rate, tnsm, tnsm_data,
      input  tnsm_clr
   );

   modport slave (
      input  active, frame_type, parity_type, stop_type, baud_rate, tnsm, tnsm_data,
      output tnsm_clr
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Loadable baud down-counter; bit_tick marks the last clock of each bit period.
module uart_baud_gen #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic [CNT_W-1:0] div_in,
   output logic             bit_tick
);

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Restart captures the divisor for the whole frame; otherwise count down and reload at zero.
   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (restart) begin
         div_d = div_in;
         cnt_d = div_in;
      end else if (en) begin
         if (cnt_q == '0) cnt_d = div_q;
         else             cnt_d = cnt_q - CNT_W'(1);
      end
   end

   assign bit_tick = en && !restart && (cnt_q == '0);

   // Counter and divisor registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: accepts a byte from the control register and serialises it on tx.
//
//  state  | meaning
//  IDLE   | line high, waiting for tnsm with active=1 and tnsm_clr=0
//  START  | start bit (tx=0)
//  DATA   | N data bits, LSB first
//  PARITY | parity bit, only when even/odd parity selected
//  STOP   | 1 or 2 stop bits; tx_done on the last clock
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int          CNT_W       = 20
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_engine_if.slave   ctrl,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_START  = START;
   localparam logic [2:0] S_DATA   = DATA;
   localparam logic [2:0] S_PARITY = PARITY;
   localparam logic [2:0] S_STOP   = STOP;

   logic [2:0]       state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   frame_t           frame_q, frame_d;
   stop_t            stop_q, stop_d;
   logic             par_en_q, par_en_d;
   logic             par_bit_q, par_bit_d;
   logic             stop_cnt_q, stop_cnt_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             tx_done_q, tx_done_d;
   logic             tnsm_clr_q, tnsm_clr_d;

   logic [CNT_W-1:0] div_sel;
   logic [7:0]       data_m;
   logic             accept;
   logic             bit_tick;

   // Divisor lookup; every table entry folds to a constant for the given clock.
   always_comb begin
      div_sel = '0;
      for (int i = 0; i < 16; i++) begin
         if (ctrl.baud_rate == 4'(i)) div_sel = CNT_W'(baud_div(CLK_FREQ_HZ, 4'(i)));
      end
   end

   assign data_m = ctrl.tnsm_data & data_mask(ctrl.frame_type);
   assign accept = (state_q == S_IDLE) && ctrl.tnsm && ctrl.active && !tnsm_clr_q;

   uart_baud_gen #(.CNT_W(CNT_W)) u_baud_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (state_q != S_IDLE),
      .restart  (accept),
      .div_in   (div_sel),
      .bit_tick (bit_tick)
   );

   // Frame sequencing, shift register and tnsm_clr handshake.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      frame_d    = frame_q;
      stop_d     = stop_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      tx_done_d  = 1'b0;
      tnsm_clr_d = tnsm_clr_q;

      // Retire only once the register has really dropped the request.
      if (tnsm_clr_q && !ctrl.tnsm) tnsm_clr_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d    = S_START;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               tnsm_clr_d = 1'b1;
               shift_d    = ctrl.tnsm_data;
               frame_d    = ctrl.frame_type;
               stop_d     = ctrl.stop_type;
               par_en_d   = (ctrl.parity_type == PAR_EVEN) || (ctrl.parity_type == PAR_ODD);
               par_bit_d  = (ctrl.parity_type == PAR_ODD) ? ~^data_m : ^data_m;
            end
         end
         S_START: begin
            if (bit_tick) begin
               state_d   = S_DATA;
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_idx_d = 3'd0;
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == last_bit_idx(frame_q)) begin
                  if (par_en_q) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d    = S_STOP;
                     tx_d       = 1'b1;
                     stop_cnt_d = 1'b0;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               state_d    = S_STOP;
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               if ((stop_q == STOP_2) && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  state_d   = S_IDLE;
                  busy_d    = 1'b0;
                  tx_done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers; reset aborts any frame and returns the line high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         frame_q    <= FRAME_5;
         stop_q     <= STOP_1;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         tx_done_q  <= 1'b0;
         tnsm_clr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         frame_q    <= frame_d;
         stop_q     <= stop_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         tx_done_q  <= tx_done_d;
         tnsm_clr_q <= tnsm_clr_d;
      end
   end

   assign tx            = tx_q;
   assign busy          = busy_q;
   assign tx_done       = tx_done_q;
   assign ctrl.tnsm_clr = tnsm_clr_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine at 1.152 MHz; baud index 12 gives 10 clocks per bit.
module tb_uart_tx_engine;
   import uart_pkg::*;

   typedef logic [255:0] val_t;

   logic clk = 1'b0;
   logic rst;
   logic tx, busy, tx_done;

   uart_tx_engine_if ifc ();

   uart_tx_engine #(.CLK_FREQ_HZ(1_152_000), .CNT_W(20)) dut (
      .clk     (clk),
      .rst     (rst),
      .ctrl    (ifc),
      .tx      (tx),
      .busy    (busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input val_t got, input val_t exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Frame monitor: records tx once per clock while busy is high.
   int   frames = 0;
   bit   in_frame = 1'b0;
   val_t cur_wave, last_wave;
   int   cur_len = 0, last_len = 0, done_in = 0;
   bit   last_done_ok = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
      end else if (busy) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            cur_wave = '0;
            cur_len  = 0;
            done_in  = 0;
         end
         if (cur_len < 256) cur_wave[cur_len] = tx;
         cur_len++;
         if (tx_done) done_in++;
      end else if (in_frame) begin
         in_frame     = 1'b0;
         last_wave    = cur_wave;
         last_len     = cur_len;
         last_done_ok = (tx_done === 1'b1) && (done_in == 0) && (tx === 1'b1);
         frames++;
      end
   end

   // Expected per-clock waveform from a bit string written in transmission order.
   function automatic val_t expand(input string s, input int per);
      val_t w = '0;
      for (int k = 0; k < s.len(); k++)
         for (int j = 0; j < per; j++)
            if (k * per + j < 256) w[k * per + j] = (s[k] == 8'h31);
      return w;
   endfunction

   int f_snap = 0;

   task automatic start_frame(input string tag, input bit drop);
      int t = 0;
      @(negedge clk); #1;
      f_snap    = frames;
      ifc.tnsm  = 1'b1;
      while (busy !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check({tag, " start"}, val_t'(busy), val_t'(1));
      check({tag, " clr set"}, val_t'(ifc.tnsm_clr), val_t'(1));
      if (drop) ifc.tnsm = 1'b0;
   endtask

   task automatic wait_frame(input string tag, input string s, input int per);
      int t = 0;
      while (frames == f_snap && t < 600) begin
         @(negedge clk); #1;
         t++;
      end
      check({tag, " frames"}, val_t'(frames - f_snap), val_t'(1));
      check({tag, " len"}, val_t'(last_len), val_t'(s.len() * per));
      check({tag, " wave"}, last_wave, expand(s, per));
      check({tag, " done pulse"}, val_t'(last_done_ok), val_t'(1));
   endtask

   task automatic set_cfg(input frame_t f, input parity_t p, input stop_t s,
                          input logic [3:0] b, input logic [7:0] d);
      ifc.frame_type  = f;
      ifc.parity_type = p;
      ifc.stop_type   = s;
      ifc.baud_rate   = b;
      ifc.tnsm_data   = d;
   endtask

   initial begin
      int cnt;
      rst        = 1'b1;
      ifc.active = 1'b1;
      ifc.tnsm   = 1'b0;
      set_cfg(FRAME_8, PAR_NONE, STOP_1, 4'd12, 8'h00);
      repeat (3) @(negedge clk);
      check("rst tx", val_t'(tx), val_t'(1));
      check("rst busy", val_t'(busy), val_t'(0));
      check("rst done", val_t'(tx_done), val_t'(0));
      check("rst clr", val_t'(ifc.tnsm_clr), val_t'(0));
      rst = 1'b0;

      // 8N1 0xA5
      set_cfg(FRAME_8, PAR_NONE, STOP_1, 4'd12, 8'hA5);
      start_frame("t1", 1'b1);
      @(negedge clk);
      check("t1 clr drop", val_t'(ifc.tnsm_clr), val_t'(0));
      wait_frame("t1", "0101001011", 10);

      // 7E2 0x83: data 1100000 LSB first, even parity 0
      set_cfg(FRAME_7, PAR_EVEN, STOP_2, 4'd12, 8'h83);
      start_frame("t2", 1'b1);
      wait_frame("t2", "01100000011", 10);

      // 5O1 0x1F: data 11111, odd parity 0
      set_cfg(FRAME_5, PAR_ODD, STOP_1, 4'd12, 8'h1F);
      start_frame("t3", 1'b1);
      wait_frame("t3", "01111101", 10);

      // 5E1 0xE0: upper bits ignored for data and parity
      set_cfg(FRAME_5, PAR_EVEN, STOP_1, 4'd12, 8'hE0);
      start_frame("t3b", 1'b1);
      wait_frame("t3b", "00000001", 10);

      // Config change during the third data bit; next frame 5N1 0xFF at 20 clk/bit
      set_cfg(FRAME_8, PAR_NONE, STOP_1, 4'd12, 8'h3C);
      start_frame("t4 cur", 1'b1);
      repeat (32) @(negedge clk);
      set_cfg(FRAME_5, PAR_NONE, STOP_1, 4'd11, 8'hFF);
      wait_frame("t4 cur", "0001111001", 10);
      start_frame("t4 next", 1'b1);
      wait_frame("t4 next", "0111111", 20);

      // tnsm held high across tnsm_clr
      set_cfg(FRAME_8, PAR_NONE, STOP_1, 4'd12, 8'h5A);
      start_frame("t5 first", 1'b0);
      wait_frame("t5 first", "0010110101", 10);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      check("t5 no reaccept", val_t'(cnt), val_t'(0));
      check("t5 clr held", val_t'(ifc.tnsm_clr), val_t'(1));
      ifc.tnsm = 1'b0;
      @(negedge clk);
      check("t5 clr drop", val_t'(ifc.tnsm_clr), val_t'(0));
      ifc.tnsm_data = 8'h01;
      start_frame("t5 second", 1'b1);
      wait_frame("t5 second", "0100000001", 10);
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      check("t5 single", val_t'(cnt), val_t'(0));

      // Reset during the fourth data bit
      ifc.tnsm_data = 8'h00;
      start_frame("t6 abort", 1'b0);
      repeat (44) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6 rst tx", val_t'(tx), val_t'(1));
      check("t6 rst busy", val_t'(busy), val_t'(0));
      check("t6 rst clr", val_t'(ifc.tnsm_clr), val_t'(0));
      ifc.tnsm = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // active=0 holds the request pending
      ifc.tnsm_data = 8'h0F;
      ifc.active    = 1'b0;
      ifc.tnsm      = 1'b1;
      #1;
      f_snap = frames;
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      check("t6 inactive busy", val_t'(cnt), val_t'(0));
      check("t6 inactive clr", val_t'(ifc.tnsm_clr), val_t'(0));
      check("t6 inactive frames", val_t'(frames - f_snap), val_t'(0));
      ifc.active = 1'b1;
      start_frame("t6 pending", 1'b1);
      wait_frame("t6 pending", "0111100001", 10);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
